// File: rtl/rv_instr_fetch.sv
// RV32I instruction fetch: word-aligned request generator, in-order response buffer
// with PC tagging, redirect flush with stale-response dropping, and opcode legality flag.
module rv_instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_illegal,
  input  logic        instr_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_S = (CW+1)'(FIFO_DEPTH);

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_SYSTEM: is_legal = 1'b1;
      default:                            is_legal = 1'b0;
    endcase
  endfunction

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW-1:0] ir_q, ir_d, iw_q, iw_d;

  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] ifq_pc_q    [FIFO_DEPTH];

  logic [CW:0] used;
  logic        req_fire, rsp_fire, pop, push;
  logic        unused_ok;

  assign unused_ok = ^redirect_pc[1:0];

  // Issue is gated by reset so no request leaves while rst_n is held low.
  assign used           = {1'b0, out_q} + {1'b0, cnt_q};
  assign imem_req_valid = rst_n && (used < DEPTH_S);
  assign imem_req_addr  = pc_q;

  assign instr_valid   = (cnt_q != '0);
  assign instr_data    = instr_valid ? fifo_data_q[rd_q] : '0;
  assign instr_pc      = instr_valid ? fifo_pc_q[rd_q]   : '0;
  assign instr_illegal = instr_valid && !is_legal(fifo_data_q[rd_q][6:0]);

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (out_q != '0);
  assign pop      = instr_valid && instr_ready;
  assign push     = rsp_fire && !redirect_valid && (drop_q == '0);

  always_comb begin
    out_d = out_q + CW'(req_fire) - CW'(rsp_fire);
    ir_d  = ir_q + AW'(rsp_fire);
    iw_d  = iw_q + AW'(req_fire);
    pc_d  = req_fire ? pc_q + 32'd4 : pc_q;
    drop_d = drop_q - CW'(rsp_fire && (drop_q != '0));
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    rd_d   = rd_q + AW'(pop);
    wr_d   = wr_q + AW'(push);
    // Every request still in flight after a redirect belongs to the old path.
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      drop_d = out_d;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      ir_q   <= '0;
      iw_q   <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      ir_q   <= ir_d;
      iw_q   <= iw_d;
    end
  end

  // Storage carries data only; validity is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (req_fire) ifq_pc_q[iw_q] <= pc_q;
    if (push) begin
      fifo_pc_q[wr_q]   <= ifq_pc_q[ir_q];
      fifo_data_q[wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_rv_instr_fetch.sv
// Bench for rv_instr_fetch: bench-side memory, expected fetch/delivery stream model,
// and directed scenarios with literal expectations.
module tb_rv_instr_fetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_illegal;
  logic        instr_ready = 1'b0;

  always #5 clk = ~clk;

  rv_instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
    .instr_illegal(instr_illegal), .instr_ready(instr_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mem_lat = 1;
  int n_acc = 0;
  int n_pop = 0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_req = RPC;
  logic [31:0] exp_pc = RPC;
  bit          chk_en = 1'b0;

  bit          ev_acc, ev_rsp, ev_pop, ev_red, ev_ill;
  logic [31:0] ev_addr, ev_tgt, ev_pc, ev_data;

  // Memory image: a few fixed words, otherwise a PC-derived word cycling through opcodes.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    if (a == 32'h200) return 32'h0000_0000;
    if (a == 32'h204) return 32'h0000_0013;
    case (a[4:2])
      3'd0: op = 7'h13;
      3'd1: op = 7'h33;
      3'd2: op = 7'h03;
      3'd3: op = 7'h23;
      3'd4: op = 7'h63;
      3'd5: op = 7'h17;
      3'd6: op = 7'h6F;
      default: op = 7'h12;
    endcase
    return {a[26:2], op};
  endfunction

  function automatic bit legal_op(input logic [31:0] w);
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h73: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: compare at negedge, then advance the model and the memory after posedge.
  task automatic step();
    @(negedge clk);
    ev_acc  = imem_req_valid && imem_req_ready;
    ev_addr = imem_req_addr;
    ev_rsp  = imem_rsp_valid;
    ev_pop  = instr_valid && instr_ready;
    ev_pc   = instr_pc;
    ev_data = instr_data;
    ev_ill  = instr_illegal;
    ev_red  = redirect_valid;
    ev_tgt  = redirect_pc;
    if (chk_en) begin
      if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
      chk("outstanding_bound", 32'(mq_addr.size() + (imem_rsp_valid ? 1 : 0) <= DEPTH), 32'd1);
      if (!redirect_valid) begin
        if (instr_valid) begin
          chk("instr_pc", instr_pc, exp_pc);
          chk("instr_data", instr_data, mem_word(exp_pc));
        end
        chk("instr_illegal", 32'(instr_illegal), 32'(instr_valid && !legal_op(mem_word(exp_pc))));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ev_acc) begin
      mq_addr.push_back(ev_addr);
      mq_due.push_back(cyc - 1 + mem_lat);
      n_acc++;
    end
    if (ev_red) begin
      exp_req = {ev_tgt[31:2], 2'b00};
      exp_pc  = {ev_tgt[31:2], 2'b00};
    end else begin
      if (ev_acc) exp_req = exp_req + 32'd4;
      if (ev_pop) begin
        exp_pc = exp_pc + 32'd4;
        n_pop++;
      end
    end
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    redirect_valid = 1'b0;
  endtask

  task automatic wait_pop(input string nm, input logic [31:0] pc, input logic [31:0] data,
                          input logic ill);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (ev_pop) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no instruction delivered within 40 cycles, expected pc %h", nm, pc);
    end else begin
      chk({nm, "_pc"}, ev_pc, pc);
      chk({nm, "_data"}, ev_data, data);
      chk({nm, "_ill"}, 32'(ev_ill), 32'(ill));
    end
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({nm, "_req_addr"}, imem_req_addr, RPC);
    chk({nm, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({nm, "_instr_data"}, instr_data, 32'd0);
    chk({nm, "_instr_pc"}, instr_pc, 32'd0);
    chk({nm, "_instr_illegal"}, 32'(instr_illegal), 32'd0);
  endtask

  task automatic do_redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int inflight;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");

    // Release with decode stalled: fill buffer, then drain in order.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    chk_en = 1'b1;
    exp_req = RPC;
    exp_pc = RPC;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RPC);
    n_acc = 0;
    repeat (10) step();
    chk("stall_reqs", 32'(n_acc), 32'(DEPTH));
    #1;
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    wait_pop("drain0", 32'h0, 32'h0000_0013, 1'b0);
    wait_pop("drain1", 32'h4, 32'h0000_00B3, 1'b0);
    n_pop = 0;
    repeat (20) step();
    chk("throughput", 32'(n_pop), 32'd20);

    // Redirect while at least two responses are outstanding at a slow memory.
    mem_lat = 3;
    inflight = 0;
    for (int i = 0; i < 20; i++) begin
      inflight = mq_addr.size() + (imem_rsp_valid ? 1 : 0);
      if (inflight >= 2) break;
      step();
    end
    chk("inflight_ge2", 32'(inflight >= 2), 32'd1);
    do_redirect(32'h100);
    mem_lat = 1;
    wait_pop("redir100", 32'h100, 32'h0000_2013, 1'b0);

    // Misaligned target: low bits dropped.
    do_redirect(32'h103);
    #1;
    chk("misalign_req_valid", 32'(imem_req_valid), 32'd1);
    chk("misalign_req_addr", imem_req_addr, 32'h100);
    wait_pop("redir103", 32'h100, 32'h0000_2013, 1'b0);

    // Redirect coinciding with acceptance, response and pop.
    repeat (6) step();
    do_redirect(32'h180);
    chk("combo_events", {29'b0, ev_acc, ev_rsp, ev_pop}, 32'd7);
    wait_pop("redir180", 32'h180, 32'h0000_3013, 1'b0);

    // Illegal / legal opcode words.
    do_redirect(32'h200);
    wait_pop("zero_word", 32'h200, 32'h0000_0000, 1'b1);
    wait_pop("addi_word", 32'h204, 32'h0000_0013, 1'b0);

    // PC wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    wait_pop("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FF92, 1'b1);
    wait_pop("wrap_zero", 32'h0, 32'h0000_0013, 1'b0);

    // Asynchronous reset mid-stream.
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    chk_en = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    mq_addr.delete();
    mq_due.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    repeat (2) step();
    mq_addr.delete();
    mq_due.delete();
    rst_n = 1'b1;
    chk_en = 1'b1;
    exp_req = RPC;
    exp_pc = RPC;
    wait_pop("after_reset", 32'h0, 32'h0000_0013, 1'b0);
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
